// File: rtl/dmem_wait_responder.sv
// Data-memory responder with a programmable number of wait states, access counters and a sticky error flag.
// Each request is captured in IDLE, stalls the core for LATENCY cycles and completes on the edge into DONE.
module dmem_wait_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [63:0] ADDRESS,
    input  logic [63:0] WRITE_DATA,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    output logic [63:0] READ_DATA,
    output logic        STALL,
    output logic        ERR,
    output logic [31:0] RD_COUNT,
    output logic [31:0] WR_COUNT,
    output logic [1:0]  state_dbg_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             oor_q;
    logic             wr_q;
    logic [63:0]      wdata_q;
    logic [63:0]      rdata_q;
    logic             err_q;
    logic [31:0]      rd_cnt_q;
    logic [31:0]      wr_cnt_q;
    logic [63:0]      mem_q [DEPTH];

    logic             req;
    logic             in_oor;
    logic             in_err;
    logic             acc_go;
    logic             acc_wr;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_oor;
    logic [63:0]      acc_data;

    assign req    = MEM_READ | MEM_WRITE;
    assign in_oor = |ADDRESS[63:3+IDX_W];
    assign in_err = (MEM_READ & MEM_WRITE) | (|ADDRESS[2:0]) | in_oor;

    // The access fires on the edge into DONE; with LATENCY=1 that edge is the capture edge,
    // so the live inputs are used instead of the captured copies.
    always_comb begin
        acc_go   = 1'b0;
        acc_wr   = wr_q;
        acc_idx  = idx_q;
        acc_oor  = oor_q;
        acc_data = wdata_q;
        if (state_q == IDLE) begin
            acc_go   = req && (LATENCY == 1);
            acc_wr   = MEM_WRITE;
            acc_idx  = ADDRESS[3 +: IDX_W];
            acc_oor  = in_oor;
            acc_data = WRITE_DATA;
        end else if (state_q == WAIT) begin
            acc_go = (cnt_q == 4'd0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            oor_q    <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= 64'd0;
            rdata_q  <= 64'd0;
            err_q    <= 1'b0;
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 64'd0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        idx_q   <= ADDRESS[3 +: IDX_W];
                        oor_q   <= in_oor;
                        wr_q    <= MEM_WRITE;
                        wdata_q <= WRITE_DATA;
                        err_q   <= err_q | in_err;
                        cnt_q   <= CNT_INIT;
                        state_q <= (LATENCY == 1) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (acc_go) begin
                if (acc_wr) begin
                    if (!acc_oor) begin
                        mem_q[acc_idx] <= acc_data;
                    end
                    wr_cnt_q <= wr_cnt_q + 32'd1;
                end else begin
                    rdata_q  <= acc_oor ? 64'd0 : mem_q[acc_idx];
                    rd_cnt_q <= rd_cnt_q + 32'd1;
                end
            end
        end
    end

    assign STALL       = ((state_q == IDLE) && req) || (state_q == WAIT);
    assign READ_DATA   = rdata_q;
    assign ERR         = err_q;
    assign RD_COUNT    = rd_cnt_q;
    assign WR_COUNT    = wr_cnt_q;
    assign state_dbg_o = state_q;

endmodule
